// File: rtl/pcs_link_status_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcs_link_status_pkg : encodings shared by the PCS link status blocks | rev 1.0
// ---------------------------------------------------------------------------
package pcs_link_status_pkg;

  localparam logic [2:0] ST_INACTIVE   = 3'b000;
  localparam logic [2:0] ST_COUNT_DOWN = 3'b001;
  localparam logic [2:0] ST_COUNT_UP   = 3'b010;
  localparam logic [2:0] ST_HOLD_OFF   = 3'b011;
  localparam logic [2:0] ST_ACTIVE     = 3'b100;
  localparam logic [2:0] ST_HOLD_ON    = 3'b101;

  localparam logic [1:0] RX_BEACON    = 2'b00;
  localparam logic [1:0] RX_COMMIT    = 2'b01;
  localparam logic [1:0] RX_HEARTBEAT = 2'b10;
  localparam logic [1:0] RX_NONE      = 2'b11;

  localparam logic STATUS_OK     = 1'b1;
  localparam logic STATUS_NOT_OK = 1'b0;

endpackage
`default_nettype wire

// File: rtl/pcs_link_status_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcs_link_status_ch : one link status FSM with hold timer and counters | rev 1.0
// ---------------------------------------------------------------------------
module pcs_link_status_ch
  import pcs_link_status_pkg::*;
#(
  parameter int CNT_W            = 4,
  parameter int LINK_HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pcs_reset,
  input  logic             i_mr_autoneg_enable,
  input  logic             i_an_link_good,
  input  logic             i_multidrop,
  input  logic [1:0]       i_rx_cmd,
  input  logic             i_rx_dv,
  input  logic             i_crs,
  input  logic [CNT_W-1:0] i_active_cnt,
  input  logic [CNT_W-1:0] i_inactive_cnt,
  input  logic             i_link_lost_clr,
  output logic [2:0]       o_state,
  output logic             o_pcs_status,
  output logic             o_status_change,
  output logic             o_link_lost,
  output logic [CNT_W-1:0] o_cnt_h,
  output logic [CNT_W-1:0] o_cnt_l
);

  localparam int               TMR_W        = $clog2(LINK_HOLD_CYCLES);
  localparam logic [TMR_W-1:0] C_TMR_RELOAD = TMR_W'(LINK_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt_h;
  logic [CNT_W-1:0] r_cnt_l;
  logic [CNT_W-1:0] w_cnt_h_nxt;
  logic [CNT_W-1:0] w_cnt_l_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             r_status;
  logic             w_status_nxt;
  logic             r_status_change;
  logic             r_link_lost;
  logic             w_reload;
  logic             w_enter;
  logic             w_force;
  logic             w_hb;
  logic             w_act;
  logic             w_idle;
  logic             w_timer_done;

  assign w_force = i_pcs_reset | ~i_mr_autoneg_enable | ~i_an_link_good | i_multidrop;
  assign w_hb    = (i_rx_cmd == RX_HEARTBEAT);
  assign w_act   = w_hb | i_rx_dv;
  assign w_idle  = (i_rx_cmd == RX_NONE) & ~i_rx_dv;
  // A reload only happens on entry to COUNT_UP/ACTIVE, never on a path that
  // consults timer_done, so the zero test alone is sufficient here.
  assign w_timer_done = (r_timer == '0);
  assign w_enter      = (w_state_nxt != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INACTIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INACTIVE: begin
        if (w_act) w_state_nxt = ST_COUNT_UP;
      end
      ST_COUNT_UP: begin
        if (r_cnt_h >= i_active_cnt)  w_state_nxt = ST_ACTIVE;
        else if (w_idle && !i_crs)    w_state_nxt = ST_HOLD_OFF;
      end
      ST_HOLD_OFF: begin
        if (w_act)                      w_state_nxt = ST_COUNT_UP;
        else if (w_timer_done && w_idle) w_state_nxt = ST_INACTIVE;
      end
      ST_ACTIVE: begin
        if (w_act)             w_state_nxt = ST_HOLD_ON;
        else if (w_timer_done) w_state_nxt = ST_COUNT_DOWN;
      end
      ST_HOLD_ON: begin
        if (w_idle) w_state_nxt = ST_ACTIVE;
      end
      ST_COUNT_DOWN: begin
        if (r_cnt_l == i_inactive_cnt) w_state_nxt = ST_INACTIVE;
        else                           w_state_nxt = ST_ACTIVE;
      end
      default: w_state_nxt = ST_INACTIVE;
    endcase
    if (w_force) w_state_nxt = ST_INACTIVE;
  end

  // Entry actions fire only on a real state change; INACTIVE always clears.
  always_comb begin
    w_cnt_h_nxt  = r_cnt_h;
    w_cnt_l_nxt  = r_cnt_l;
    w_status_nxt = r_status;
    w_reload     = 1'b0;
    if (w_state_nxt == ST_INACTIVE) begin
      w_cnt_h_nxt  = '0;
      w_cnt_l_nxt  = '0;
      w_status_nxt = STATUS_NOT_OK;
    end else if (w_enter) begin
      case (w_state_nxt)
        ST_COUNT_UP: begin
          if (r_cnt_h != C_CNT_MAX) w_cnt_h_nxt = r_cnt_h + 1'b1;
          w_reload = 1'b1;
        end
        ST_ACTIVE: begin
          w_status_nxt = STATUS_OK;
          w_reload     = 1'b1;
        end
        ST_COUNT_DOWN: begin
          if (r_cnt_l != C_CNT_MAX) w_cnt_l_nxt = r_cnt_l + 1'b1;
        end
        ST_HOLD_ON: w_cnt_l_nxt = '0;
        default: ;
      endcase
    end
    if (w_reload)            w_timer_nxt = C_TMR_RELOAD;
    else if (r_timer != '0)  w_timer_nxt = r_timer - 1'b1;
    else                     w_timer_nxt = r_timer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_h         <= '0;
      r_cnt_l         <= '0;
      r_timer         <= '0;
      r_status        <= STATUS_NOT_OK;
      r_status_change <= 1'b0;
      r_link_lost     <= 1'b0;
    end else begin
      r_cnt_h         <= w_cnt_h_nxt;
      r_cnt_l         <= w_cnt_l_nxt;
      r_timer         <= w_timer_nxt;
      r_status        <= w_status_nxt;
      r_status_change <= w_status_nxt ^ r_status;
      r_link_lost     <= (r_status & ~w_status_nxt) | (r_link_lost & ~i_link_lost_clr);
    end
  end

  assign o_state         = r_state;
  assign o_pcs_status    = r_status;
  assign o_status_change = r_status_change;
  assign o_link_lost     = r_link_lost;
  assign o_cnt_h         = r_cnt_h;
  assign o_cnt_l         = r_cnt_l;

endmodule
`default_nettype wire

// File: rtl/pcs_link_status_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcs_link_status_mc : NUM_CH independent PCS link status channels | rev 1.0
// ---------------------------------------------------------------------------
module pcs_link_status_mc
  import pcs_link_status_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int CNT_W            = 4,
  parameter int LINK_HOLD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       i_pcs_reset,
  input  logic                    i_mr_autoneg_enable,
  input  logic [NUM_CH-1:0]       i_an_link_good,
  input  logic [NUM_CH-1:0]       i_multidrop,
  input  logic [2*NUM_CH-1:0]     i_rx_cmd,
  input  logic [NUM_CH-1:0]       i_rx_dv,
  input  logic [NUM_CH-1:0]       i_crs,
  input  logic [CNT_W-1:0]        i_active_cnt,
  input  logic [CNT_W-1:0]        i_inactive_cnt,
  input  logic [NUM_CH-1:0]       i_link_lost_clr,
  output logic [3*NUM_CH-1:0]     o_state,
  output logic [NUM_CH-1:0]       o_pcs_status,
  output logic [NUM_CH-1:0]       o_status_change,
  output logic [NUM_CH-1:0]       o_link_lost,
  output logic [CNT_W*NUM_CH-1:0] o_cnt_h,
  output logic [CNT_W*NUM_CH-1:0] o_cnt_l
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pcs_link_status_ch #(
      .CNT_W           (CNT_W),
      .LINK_HOLD_CYCLES(LINK_HOLD_CYCLES)
    ) u_ch (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_pcs_reset        (i_pcs_reset[g]),
      .i_mr_autoneg_enable(i_mr_autoneg_enable),
      .i_an_link_good     (i_an_link_good[g]),
      .i_multidrop        (i_multidrop[g]),
      .i_rx_cmd           (i_rx_cmd[2*g +: 2]),
      .i_rx_dv            (i_rx_dv[g]),
      .i_crs              (i_crs[g]),
      .i_active_cnt       (i_active_cnt),
      .i_inactive_cnt     (i_inactive_cnt),
      .i_link_lost_clr    (i_link_lost_clr[g]),
      .o_state            (o_state[3*g +: 3]),
      .o_pcs_status       (o_pcs_status[g]),
      .o_status_change    (o_status_change[g]),
      .o_link_lost        (o_link_lost[g]),
      .o_cnt_h            (o_cnt_h[CNT_W*g +: CNT_W]),
      .o_cnt_l            (o_cnt_l[CNT_W*g +: CNT_W])
    );
  end

endmodule
`default_nettype wire

// File: doc/pcs_link_status_mc.md
Name: pcs_link_status_mc

Overview:
- Parametrised, clocked, multi-channel successor to the Clause 147.11 PCS link status state diagram for 10BASE-T1S point-to-point PHYs.
- Runs NUM_CH independent per-channel link status FSMs, each with its own integrated link_hold_timer.
- Adds configurable counter widths, a per-channel status-change pulse and a sticky link-lost flag for management.
- Sits between the per-channel PCS receive path (rx_cmd/RX_DV/CRS) and the management/PLCA layers.

Parameters:
- NUM_CH, 2, number of independent channels (1..16).
- CNT_W, 4, width of cnt_h/cnt_l and of the ACTIVE_CNT/INACTIVE_CNT thresholds.
- LINK_HOLD_CYCLES, 16, link_hold_timer duration in clk cycles (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pcs_reset  in  NUM_CH  per-channel PCS reset.
- mr_autoneg_enable  in  1  global AN enable.
- an_link_good  in  NUM_CH  per-channel AN link good.
- multidrop  in  NUM_CH  per-channel multidrop mode.
- rx_cmd  in  2*NUM_CH  per-channel rx_cmd: 00 BEACON, 01 COMMIT, 10 HEARTBEAT, 11 NONE.
- rx_dv  in  NUM_CH  per-channel RX_DV.
- crs  in  NUM_CH  per-channel CRS.
- active_cnt  in  CNT_W  ACTIVE_CNT threshold, shared by all channels.
- inactive_cnt  in  CNT_W  INACTIVE_CNT threshold, shared by all channels.
- link_lost_clr  in  NUM_CH  clear for link_lost.
- state  out  3*NUM_CH  per-channel FSM state.
- pcs_status  out  NUM_CH  1 = OK, 0 = NOT_OK.
- status_change  out  NUM_CH  one-cycle pulse on any pcs_status edge.
- link_lost  out  NUM_CH  sticky; set on a pcs_status 1->0 transition.
- cnt_h  out  CNT_W*NUM_CH  per-channel up counter.
- cnt_l  out  CNT_W*NUM_CH  per-channel down counter.

Behaviour:
- Reset (rst_n=0, asynchronous): state=INACTIVE, cnt_h=cnt_l=0, timer=0, pcs_status=0, status_change=0, link_lost=0.
- State encodings: INACTIVE 000, COUNT_DOWN 001, COUNT_UP 010, HOLD_OFF 011, ACTIVE 100, HOLD_ON 101. Encodings 110/111 go to INACTIVE on the next clock.
- Per-channel force condition: force = pcs_reset | !mr_autoneg_enable | !an_link_good | multidrop. While force is high, the next state is INACTIVE. Force dominates every other transition, including mid-timer and mid-count.
- State, counters and pcs_status are registered. Entry actions take effect in the same clock edge as the transition, so they are visible 1 cycle after the triggering inputs.
- Entry actions:
  - INACTIVE: pcs_status=0, cnt_h=0, cnt_l=0.
  - COUNT_UP: cnt_h+1 (saturates at 2^CNT_W-1), timer reload.
  - ACTIVE: pcs_status=1, timer reload.
  - COUNT_DOWN: cnt_l+1 (saturating).
  - HOLD_ON: cnt_l=0.
  - Self-loops do not repeat entry actions.
- Timer: reload sets timer=LINK_HOLD_CYCLES-1. Timer decrements each cycle while nonzero. timer_done = (timer==0) and no reload in the current cycle. First done occurs LINK_HOLD_CYCLES cycles after the entry edge.
- Transitions (hb = rx_cmd==HEARTBEAT; idle = rx_cmd==NONE & !rx_dv):
  - INACTIVE: hb | rx_dv -> COUNT_UP.
  - COUNT_UP: cnt_h>=active_cnt -> ACTIVE (priority); else idle & !crs -> HOLD_OFF.
  - HOLD_OFF: hb | rx_dv -> COUNT_UP (priority); else timer_done & idle -> INACTIVE.
  - ACTIVE: hb | rx_dv -> HOLD_ON (priority); else timer_done -> COUNT_DOWN.
  - HOLD_ON: idle -> ACTIVE (restarts timer).
  - COUNT_DOWN: cnt_l==inactive_cnt -> INACTIVE; else -> ACTIVE (unconditional, 1 cycle).
- status_change: registered XOR of pcs_status and its previous value; high for exactly 1 cycle.
- link_lost: set on a pcs_status 1->0 transition, cleared by link_lost_clr. If set and clear occur in the same cycle, set wins.
- Thresholds: active_cnt/inactive_cnt changes take effect immediately. active_cnt=0 gives ACTIVE on the cycle after COUNT_UP entry.
- Channels are fully independent. No cross-channel state.

Decomposition:
- Shared package pcs_link_status_pkg holds:
  - state encodings;
  - rx_cmd encodings (BEACON, COMMIT, HEARTBEAT, NONE);
  - OK/NOT_OK constants.
- Sub-module pcs_link_status_ch (one FSM, timer, counters, status_change/link_lost logic) is instantiated NUM_CH times via generate. The top level only slices and concatenates the vectors.

Test Plan:
Common settings: NUM_CH=2, LINK_HOLD_CYCLES=8, active_cnt=3, inactive_cnt=2, force low unless stated.
- Reset: assert rst_n=0 mid-ACTIVE -> all outputs 0 immediately; state=000 on both channels.
- Bring-up: ch0 1-cycle HEARTBEAT every 4 cycles -> COUNT_UP(cnt_h=1) -> HOLD_OFF -> COUNT_UP(cnt_h=2) -> HOLD_OFF -> COUNT_UP(cnt_h=3) -> ACTIVE; pcs_status=1 and status_change pulses 1 cycle; ch1 stays INACTIVE.
- Hold-off expiry: single HEARTBEAT, then NONE for 10 cycles -> HOLD_OFF; INACTIVE reached 8 cycles after COUNT_UP entry; cnt_h=0; pcs_status never rises.
- Loss: ACTIVE with rx_cmd=NONE -> COUNT_DOWN(cnt_l=1) -> ACTIVE -> COUNT_DOWN(cnt_l=2) -> INACTIVE; pcs_status falls; link_lost=1 until link_lost_clr; set/clear in the same cycle -> remains 1.
- Keepalive: in ACTIVE, HEARTBEAT every 5 cycles -> HOLD_ON (cnt_l=0) -> ACTIVE each time; COUNT_DOWN never entered.
- Force: ch1 ACTIVE, pulse multidrop[1] for 1 cycle -> ch1 INACTIVE next cycle, counters 0, link_lost[1]=1; ch0 unaffected.
